rx_uart: RTL
============

# rx_uart

UART receiver; the receive-side counterpart of the team's 8N1 transmitter. It recovers bytes from an asynchronous serial line using an oversampling enable tick supplied by the shared baud generator. Each received byte is presented on a parallel output with a single-cycle valid strobe and a framing-error flag. It sits between the pad-level `rx` line and the byte-consuming logic: command parser or FIFO.

## Interface
- `OVERSAMPLE`, default 16: `sample_tick` pulses per bit period. Must be even and ≥4.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `sample_tick`  in  1  one-`clk` enable pulse at OVERSAMPLE × baud rate.
- `rx_bit_i`  in  1  asynchronous serial line, idle high.
- `rx_data_o`  out  8  last correctly framed byte. Reset value 8'h00.
- `rx_valid_o`  out  1  one-`clk` pulse when `rx_data_o` is updated. Reset value 0.
- `frame_err_o`  out  1  one-`clk` pulse when the stop bit is sampled low. Reset value 0.
- `parity_err_o`  out  1  one-`clk` pulse on parity mismatch; tied 0 without the macro. Reset value 0.
- `busy_o`  out  1  high in any state other than IDLE. Reset value 0.

## Operation
- **Input synchronizer:** `rx_bit_i` passes through a 2-FF synchronizer; both flops reset to 1. All decisions use the synchronized value `rxs`.
- **Tick counter:** `tick_cnt` is $clog2(OVERSAMPLE) bits wide. It advances only on `sample_tick` and is cleared on every state entry.
- **Edge detect:** `prev_s` holds `rxs` as sampled at the previous tick; it resets to 1.
- **IDLE:**
  - On a tick where `prev_s`=1 and `rxs`=0, go to START.
  - Because a falling edge is required, a line held low (break) never retriggers.
- **START:**
  - At the tick where `tick_cnt`=OVERSAMPLE/2−1 (mid start bit), check `rxs`.
  - If `rxs`=0, go to DATA with `bit_idx`=0.
  - Otherwise it is a false start: return to IDLE, with no output pulse.
- **DATA:**
  - Every OVERSAMPLE ticks, at mid-bit, shift `rxs` into `shift[7]` while shifting right, so bits arrive LSB first.
  - After `bit_idx`=7 has been sampled, go to STOP (PARITY when the macro is defined).
- **STOP:** after OVERSAMPLE ticks, sample `rxs`.
  - If 1: load `rx_data_o`←`shift` and pulse `rx_valid_o`.
  - If 0: pulse `frame_err_o`; `rx_data_o` holds its old value.
  - In both cases go to IDLE.
- A new start edge is accepted on the first tick after returning to IDLE. Back-to-back frames with a single stop bit must be received.
- Ticks arriving on consecutive `clk` cycles are legal.
- **Reset mid-frame:** immediate return to IDLE. All outputs and internal registers take their reset values. The partial frame is discarded.

## Timing
- Let t0 be the tick at which the start edge is detected.
  - Start is confirmed at t0+OVERSAMPLE/2.
  - Data bit i is sampled at t0+OVERSAMPLE/2+OVERSAMPLE·(i+1).
  - Stop is sampled at t0+OVERSAMPLE/2+9·OVERSAMPLE, which is t0+152 for OVERSAMPLE=16.
- `rx_valid_o`, `frame_err_o` and `parity_err_o` are registered. Each is high for exactly the one `clk` cycle following the stop-sampling tick.
- `rx_data_o` changes in the same cycle that `rx_valid_o` rises, and is stable until the next valid pulse.
- Synchronizer latency is 2 `clk` cycles from a pin transition to `rxs`.
- `busy_o` rises the cycle after the detecting tick and falls in the same cycle as the output pulse.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - Frame is 8E1.
  - A PARITY state follows DATA. It samples one bit period later and checks even parity, XOR of the 8 data bits and the parity bit = 0.
  - STOP follows PARITY, so stop is sampled at t0+OVERSAMPLE/2+10·OVERSAMPLE.
  - On parity mismatch with a good stop bit: pulse `parity_err_o`, do not update `rx_data_o`, no `rx_valid_o`.
  - A framing error takes precedence and only `frame_err_o` pulses.
- **Not defined:** frame is 8N1, the PARITY state is absent, and `parity_err_o` is constant 0.

## Test plan
- Send 0xA5 in 8N1 (OVERSAMPLE=16, tick every 4 clk) → single `rx_valid_o` pulse, `rx_data_o`=0xA5, no error pulses, `busy_o` low afterwards.
- Send 0x3C with the stop bit driven 0, then release the line high → one `frame_err_o` pulse, `rx_valid_o` stays 0, `rx_data_o` keeps its prior value; a following 0x11 is received correctly.
- Low glitch of 4 ticks on an idle line → false start; returns to IDLE, no pulses, `rx_data_o` unchanged.
- Back-to-back 0x00 then 0xFF with no idle gap → two valid pulses with data 0x00 then 0xFF.
- Assert `rst` at data bit 4 of 0x5A, release, then send 0xC3 → all outputs 0 during reset; 0xC3 received correctly.
- With `UART_RX_PARITY_EN`: send 0x01 with parity bit 0 → `parity_err_o` pulse, no valid; send 0x01 with parity bit 1 → valid, data 0x01.

Source files
------------

// File: rtl/rx_uart.sv
`timescale 1ns/1ps
// rx_uart: oversampled UART receiver, 8N1 by default.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module rx_uart #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic       rx_bit_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       busy_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t state_q, state_d;

  logic          sync1_q;
  logic          rxs_q;
  logic          prev_s_q, prev_s_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          at_half;
  logic          at_full;

`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          perr_q, perr_d;
`endif

  assign at_half = (tick_cnt_q == HALF_M1);
  assign at_full = (tick_cnt_q == FULL_M1);

  // Two-flop synchronizer on the pad, idles high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx_bit_i;
      rxs_q   <= sync1_q;
    end
  end

  // Line level as seen at the previous tick
  always_comb begin
    prev_s_d = prev_s_q;
    if (sample_tick)
      prev_s_d = rxs_q;
  end

  // Frame FSM: next state, datapath and pulses
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    perr_d     = 1'b0;
`endif
    if (sample_tick) begin
      tick_cnt_d = tick_cnt_q + CW'(1);
      unique case (state_q)
        S_IDLE: begin
          if (prev_s_q && !rxs_q) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end
        S_START: begin
          if (at_half) begin
            tick_cnt_d = '0;
            bit_idx_d  = 3'd0;
            state_d    = rxs_q ? S_IDLE
                               : S_DATA;
          end
        end
        S_DATA: begin
          if (at_full) begin
            tick_cnt_d = '0;
            shift_d    = {rxs_q, shift_q[7:1]};
            bit_idx_d  = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (at_full) begin
            tick_cnt_d = '0;
            par_d      = rxs_q;
            state_d    = S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (at_full) begin
            tick_cnt_d = '0;
            state_d    = S_IDLE;
            if (!rxs_q) begin
              ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (^{shift_q, par_q}) begin
              perr_d = 1'b1;
`endif
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end
        end
        default: begin
          state_d    = S_IDLE;
          tick_cnt_d = '0;
        end
      endcase
    end
  end

  // Frame state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      prev_s_q   <= 1'b1;
      tick_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_s_q   <= prev_s_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Received parity bit and mismatch pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
